// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : morse_pkg
//  Description : Shared types and constants for the Morse sequencer: FSM
//                state encoding, letter codes and the 14-bit left-justified
//                on/off patterns for letters S..Z (dot = 1, dash = 111,
//                one off-unit between elements, zero-padded on the right).
//  Revision    : 1.0  initial release
// ============================================================================
package morse_pkg;

  localparam int c_pat_width = 14;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_GAP    = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    L_S = 3'd0,
    L_T = 3'd1,
    L_U = 3'd2,
    L_V = 3'd3,
    L_W = 3'd4,
    L_X = 3'd5,
    L_Y = 3'd6,
    L_Z = 3'd7
  } letter_t;

  localparam logic [c_pat_width-1:0] c_pat_s = 14'b10101_000000000;
  localparam logic [c_pat_width-1:0] c_pat_t = 14'b111_00000000000;
  localparam logic [c_pat_width-1:0] c_pat_u = 14'b1010111_0000000;
  localparam logic [c_pat_width-1:0] c_pat_v = 14'b101010111_00000;
  localparam logic [c_pat_width-1:0] c_pat_w = 14'b101110111_00000;
  localparam logic [c_pat_width-1:0] c_pat_x = 14'b11101010111_000;
  localparam logic [c_pat_width-1:0] c_pat_y = 14'b1110101110111_0;
  localparam logic [c_pat_width-1:0] c_pat_z = 14'b11101110101_000;

  function automatic logic [c_pat_width-1:0] pattern_of(input letter_t code);
    logic [c_pat_width-1:0] pat;
    pat = c_pat_s;
    case (code)
      L_S:     pat = c_pat_s;
      L_T:     pat = c_pat_t;
      L_U:     pat = c_pat_u;
      L_V:     pat = c_pat_v;
      L_W:     pat = c_pat_w;
      L_X:     pat = c_pat_x;
      L_Y:     pat = c_pat_y;
      L_Z:     pat = c_pat_z;
      default: pat = c_pat_s;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morse_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : morse_tick_gen
//  Description : Morse time-unit generator. Counts down from TICK_DIV-1 while
//                enabled and emits a registered one-cycle tick when the count
//                reaches zero, then reloads. restart reloads the counter.
//  Ports       : clock   - system clock
//                reset_n - synchronous active-low reset
//                enable  - count while high
//                restart - reload counter to TICK_DIV-1
//                tick    - one-cycle pulse per time unit
//  Revision    : 1.0  initial release
// ============================================================================
module morse_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int c_cnt_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(TICK_DIV - 1);

  logic [c_cnt_w-1:0] r_count;
  logic               r_tick;

  // The tick is registered, so the pulse lands one cycle after the count hits
  // zero; this extra cycle is what places the first output bit TICK_DIV+1
  // cycles after an accepted start.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count <= c_reload;
      r_tick  <= 1'b0;
    end else if (restart) begin
      r_count <= c_reload;
      r_tick  <= 1'b0;
    end else if (enable) begin
      if (r_count == '0) begin
        r_count <= c_reload;
        r_tick  <= 1'b1;
      end else begin
        r_count <= r_count - 1'b1;
        r_tick  <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : morse_sequencer
//  Description : Plays a buffered message of up to 8 letters (S..Z) as Morse
//                code on led. Each letter is a 14-unit pattern followed by a
//                3-unit silent gap.
//  Options     : MORSE_REPEAT_EN - when defined, the message loops until
//                abort or reset; otherwise playback stops after one pass.
//  Ports       : clock, reset_n (synchronous, active-low)
//                start/msg_len  - play request and letter count
//                abort          - stop playback immediately
//                wr_en/wr_idx/wr_code - buffer write port (idle only)
//                led            - Morse output, 1 = tone on
//                busy           - playback in progress
//                done           - one-cycle pulse per completed pass
//                letter_pos     - buffer index currently playing
//  Revision    : 1.0  initial release
// ============================================================================
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int TICK_DIV = 25000000,
  parameter int MSG_MAX  = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       abort,
  input  logic [3:0] msg_len,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [2:0] wr_code,
  output logic       led,
  output logic       busy,
  output logic       done,
  output logic [2:0] letter_pos
);

  localparam logic [3:0] c_max_len = 4'(MSG_MAX);

  state_t                 r_state, w_state_next;
  logic [c_pat_width-1:0] r_shreg, w_shreg_next;
  logic [3:0]             r_bit_cnt, w_bit_cnt_next;
  logic [1:0]             r_gap_cnt, w_gap_cnt_next;
  logic [3:0]             r_len, w_len_next;
  logic [2:0]             r_pos, w_pos_next;
  logic                   r_led, w_led_next;
  logic                   w_accept;
  logic                   w_tick;
  letter_t                r_buf [MSG_MAX];

  morse_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (busy),
    .restart (w_accept),
    .tick    (w_tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_gap_cnt <= '0;
      r_len     <= '0;
      r_pos     <= '0;
      r_led     <= 1'b0;
      for (int i = 0; i < MSG_MAX; i++) begin
        r_buf[i] <= L_S;
      end
    end else begin
      r_state   <= w_state_next;
      r_shreg   <= w_shreg_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
      r_len     <= w_len_next;
      r_pos     <= w_pos_next;
      r_led     <= w_led_next;
      if (wr_en && (r_state == ST_IDLE)) begin
        r_buf[wr_idx] <= letter_t'(wr_code);
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shreg_next   = r_shreg;
    w_bit_cnt_next = r_bit_cnt;
    w_gap_cnt_next = r_gap_cnt;
    w_len_next     = r_len;
    w_pos_next     = r_pos;
    w_led_next     = 1'b0;
    w_accept       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start && (msg_len != 4'd0)) begin
          w_accept     = 1'b1;
          w_len_next   = (msg_len > c_max_len) ? c_max_len : msg_len;
          w_pos_next   = 3'd0;
          w_state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_shreg_next   = pattern_of(r_buf[r_pos]);
        w_bit_cnt_next = 4'(c_pat_width);
        w_state_next   = ST_SHIFT;
      end
      ST_SHIFT: begin
        w_led_next = r_led;
        if (w_tick) begin
          // The final (14th) bit is always 0 because no pattern is longer
          // than 13 units, so led is already low on entry to GAP.
          w_led_next     = r_shreg[c_pat_width-1];
          w_shreg_next   = {r_shreg[c_pat_width-2:0], 1'b0};
          w_bit_cnt_next = r_bit_cnt - 4'd1;
          if (r_bit_cnt == 4'd1) begin
            w_gap_cnt_next = 2'd3;
            w_state_next   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_gap_cnt_next = r_gap_cnt - 2'd1;
          if (r_gap_cnt == 2'd1) begin
            if ({1'b0, r_pos} == (r_len - 4'd1)) begin
              w_state_next = ST_FINISH;
            end else begin
              w_pos_next   = r_pos + 3'd1;
              w_state_next = ST_LOAD;
            end
          end
        end
      end
      ST_FINISH: begin
`ifdef MORSE_REPEAT_EN
        w_pos_next   = 3'd0;
        w_state_next = ST_LOAD;
`else
        w_state_next = ST_IDLE;
`endif
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (abort && (r_state != ST_IDLE)) begin
      w_state_next = ST_IDLE;
      w_led_next   = 1'b0;
    end
  end

  assign led        = r_led;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_FINISH);
  assign letter_pos = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_morse_sequencer
//  Description : Self-checking bench for morse_sequencer with TICK_DIV = 4.
//                Expected waveforms come from a timeline model: each letter
//                occupies 68 cycles (14 bits x 4 + 3-unit gap x 4), the first
//                bit shows 5 cycles after the start edge, and patterns are
//                built from dot/dash strings.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_morse_sequencer;

  localparam int TICK_DIV = 4;

  logic       clock;
  logic       reset_n;
  logic       start;
  logic       abort;
  logic [3:0] msg_len;
  logic       wr_en;
  logic [2:0] wr_idx;
  logic [2:0] wr_code;
  logic       led;
  logic       busy;
  logic       done;
  logic [2:0] letter_pos;

  int          vectors;
  int          miscompares;
  int          mbuf [8];
  logic [13:0] pat_tab [8];

  morse_sequencer #(
    .TICK_DIV (TICK_DIV),
    .MSG_MAX  (8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .msg_len    (msg_len),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_code    (wr_code),
    .led        (led),
    .busy       (busy),
    .done       (done),
    .letter_pos (letter_pos)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [13:0] morse_pat(input int code);
    string       s;
    logic [13:0] p;
    int          pos;
    case (code)
      0: s = "...";
      1: s = "-";
      2: s = "..-";
      3: s = "...-";
      4: s = ".--";
      5: s = "-..-";
      6: s = "-.--";
      default: s = "--..";
    endcase
    p   = '0;
    pos = 13;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h2D) begin
        p[pos] = 1'b1; p[pos-1] = 1'b1; p[pos-2] = 1'b1;
        pos -= 3;
      end else begin
        p[pos] = 1'b1;
        pos -= 1;
      end
      pos -= 1;
    end
    return p;
  endfunction

  // {led, busy, done, letter_pos} expected n cycles after the start edge.
  function automatic logic [5:0] expect_at(input int n, input int len);
    int          done_n;
    int          li;
    int          off;
    int          p;
    logic        e_led;
    logic [13:0] pat;
    done_n = 69 + 68 * (len - 1);
    e_led  = 1'b0;
    if (n >= 5) begin
      li  = (n - 5) / 68;
      off = (n - 5) % 68;
      if (li < len && off < 56) begin
        pat   = pat_tab[mbuf[li]];
        e_led = pat[13 - off / 4];
      end
    end
    p = (n == 0) ? 0 : (n - 1) / 68;
    if (p > len - 1) p = len - 1;
    return {e_led, (n <= done_n), (n == done_n), 3'(p)};
  endfunction

  task automatic write_slot(input int idx, input int code);
    @(negedge clock);
    wr_en = 1'b1; wr_idx = 3'(idx); wr_code = 3'(code);
    @(posedge clock);
    #1 wr_en = 1'b0;
    mbuf[idx] = code;
  endtask

  // Plays one pass and compares every cycle; inject_n >= 0 attempts a buffer
  // write to slot 0 and a second start during playback (both must be ignored).
  task automatic play(input int mlen, input int inject_n);
    int         len;
    int         done_n;
    bit         ok;
    logic [5:0] got;
    logic [5:0] exp_v;
    len    = (mlen > 8) ? 8 : mlen;
    done_n = 69 + 68 * (len - 1);
    ok     = 1'b1;
    @(negedge clock);
    start = 1'b1; msg_len = 4'(mlen);
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 0; n <= done_n; n++) begin
      @(negedge clock);
      got   = {led, busy, done, letter_pos};
      exp_v = expect_at(n, len);
      if (ok) begin
        vectors++;
        if (got !== exp_v) begin
          miscompares++;
          ok = 1'b0;
          $display("FAIL play len=%0d cycle %0d: led/busy/done/pos got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                   mlen, n, got[5], got[4], got[3], got[2:0], exp_v[5], exp_v[4], exp_v[3], exp_v[2:0]);
        end
      end
      if (n == inject_n) begin
        wr_en = 1'b1; wr_idx = 3'd0; wr_code = 3'd7;
        start = 1'b1; msg_len = 4'd3;
      end
`ifdef MORSE_REPEAT_EN
      if (n == done_n) abort = 1'b1;
`endif
      @(posedge clock);
      #1 wr_en = 1'b0; start = 1'b0; abort = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      vectors++;
      if ({led, busy, done} !== 3'b000) begin
        miscompares++;
        $display("FAIL play_end len=%0d: led/busy/done got %b/%b/%b expected 0/0/0", mlen, led, busy, done);
      end
    end
  endtask

  task automatic check_quiet(input string name, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clock);
      if ({led, busy, done} !== 3'b000) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL %s: led/busy/done activity seen, expected all 0 for %0d cycles", name, cycles);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    vectors++;
    if ({led, busy, done, letter_pos} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset: led/busy/done/pos got %b/%b/%b/%0d expected 0/0/0/0", led, busy, done, letter_pos);
    end
    play(2, -1);  // buffer cleared to S by reset
  endtask

  task automatic test_single_t();
    write_slot(0, 1);
    play(1, -1);
  endtask

  task automatic test_zero_len();
    @(negedge clock);
    start = 1'b1; msg_len = 4'd0;
    @(posedge clock);
    #1 start = 1'b0;
    check_quiet("zero_len", 20);
  endtask

  task automatic test_two_letters();
    write_slot(0, 0);
    write_slot(1, 1);
    play(2, -1);
  endtask

  task automatic test_abort();
    int k;
    write_slot(0, 2);
    k = $urandom_range(6, 50);
    @(negedge clock);
    start = 1'b1; msg_len = 4'd1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (k) @(posedge clock);
    #1 abort = 1'b1; start = 1'b1; msg_len = 4'd1;
    @(posedge clock);
    #1 abort = 1'b0; start = 1'b0;
    @(negedge clock);
    vectors++;
    if ({led, busy, done} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort: led/busy/done got %b/%b/%b expected 0/0/0", led, busy, done);
    end
    check_quiet("abort_quiet", 80);
    play(1, -1);
  endtask

  task automatic test_write_while_busy();
    write_slot(0, 1);
    play(1, 20);
    play(1, -1);
  endtask

  task automatic test_reset_midplay();
    @(negedge clock);
    start = 1'b1; msg_len = 4'd2;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (30) @(posedge clock);
    #1 reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 8; i++) mbuf[i] = 0;
    @(negedge clock);
    vectors++;
    if ({led, busy, done, letter_pos} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_midplay: led/busy/done/pos got %b/%b/%b/%0d expected 0/0/0/0", led, busy, done, letter_pos);
    end
    check_quiet("reset_quiet", 80);
    play(3, -1);
  endtask

  task automatic test_random();
    int mlen;
    for (int r = 0; r < 5; r++) begin
      for (int w = 0; w < 8; w++) begin
        write_slot($urandom_range(0, 7), $urandom_range(0, 7));
      end
      mlen = (r == 0) ? 15 : $urandom_range(1, 15);
      play(mlen, ($urandom_range(0, 1) == 1) ? $urandom_range(0, 60) : -1);
    end
  endtask

`ifdef MORSE_REPEAT_EN
  task automatic test_repeat();
    bit         ok;
    int         off;
    logic [5:0] got;
    logic [5:0] exp_v;
    logic [13:0] pat;
    write_slot(0, 1);
    ok = 1'b1;
    @(negedge clock);
    start = 1'b1; msg_len = 4'd1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int n = 0; n < 210; n++) begin
      @(negedge clock);
      pat   = pat_tab[1];
      off   = (n - 5) % 68;
      exp_v = {(n >= 5 && off < 56) ? pat[13 - off / 4] : 1'b0,
               1'b1, (n >= 69 && (n - 69) % 68 == 0), 3'd0};
      got   = {led, busy, done, letter_pos};
      if (ok) begin
        vectors++;
        if (got !== exp_v) begin
          miscompares++;
          ok = 1'b0;
          $display("FAIL repeat cycle %0d: led/busy/done/pos got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                   n, got[5], got[4], got[3], got[2:0], exp_v[5], exp_v[4], exp_v[3], exp_v[2:0]);
        end
      end
    end
    #1 abort = 1'b1;
    @(posedge clock);
    #1 abort = 1'b0;
    check_quiet("repeat_abort", 80);
  endtask
`endif

  initial begin
    vectors = 0; miscompares = 0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; msg_len = '0;
    wr_en = 1'b0; wr_idx = '0; wr_code = '0;
    for (int i = 0; i < 8; i++) begin
      mbuf[i]    = 0;
      pat_tab[i] = morse_pat(i);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    test_reset();
    test_single_t();
    test_zero_len();
    test_two_letters();
    test_abort();
    test_write_while_busy();
    test_reset_midplay();
    test_random();
`ifdef MORSE_REPEAT_EN
    test_repeat();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
